// File: rtl/d_mem_ctrl_pkg.sv
// Shared opcode and state encodings for the bfcpu data-memory controller and its sequencer.
package d_mem_ctrl_pkg;

  localparam int unsigned D_ADDR_W = 6;
  localparam int unsigned D_DATA_W = 8;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Opcodes that need the current cell value, so they spend a cycle in WAIT.
  function automatic logic op_needs_read(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/d_mem_ctrl.sv
// Data-memory access controller: owns the data pointer, runs tape ops against a NOREG
// single-port BRAM, and zero-fills the tape after reset.
module d_mem_ctrl
  import d_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = D_ADDR_W,
  parameter int unsigned DATA_W         = D_DATA_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_do
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [2:0]        op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic              ready_c;
  logic              we_c;
  logic [DATA_W-1:0] inc_val;
  logic [DATA_W-1:0] dec_val;

  assign inc_val = mem_do + DATA_W'(1);
  assign dec_val = mem_do - DATA_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    clr_cnt_d   = clr_cnt_q;
    op_d        = op_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    ready_c     = 1'b0;
    we_c        = 1'b0;
    mem_addr    = ptr_q;
    mem_di      = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_addr  = clr_cnt_q;
        we_c      = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_IDLE: begin
        ready_c = 1'b1;
        if (cmd_valid) begin
          if (op_needs_read(cmd_op)) begin
            op_d    = cmd_op;
            state_d = ST_WAIT;
          end else begin
            rsp_valid_d = 1'b1;
            case (cmd_op)
              OP_RIGHT: ptr_d = ptr_q + ADDR_W'(1);
              OP_LEFT:  ptr_d = ptr_q - ADDR_W'(1);
              OP_STORE: begin
                we_c       = 1'b1;
                mem_di     = cmd_data;
                rsp_data_d = cmd_data;
                rsp_zero_d = (cmd_data == '0);
              end
              default: ;  // reserved opcodes complete as NOPs
            endcase
          end
        end
      end

      ST_WAIT: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
        case (op_q)
          OP_INC: begin
            we_c       = 1'b1;
            mem_di     = inc_val;
            rsp_data_d = inc_val;
            rsp_zero_d = (inc_val == '0);
          end
          OP_DEC: begin
            we_c       = 1'b1;
            mem_di     = dec_val;
            rsp_data_d = dec_val;
            rsp_zero_d = (dec_val == '0);
          end
          default: begin
            rsp_data_d = mem_do;
            rsp_zero_d = (mem_do == '0);
          end
        endcase
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr_q       <= '0;
      clr_cnt_q   <= '0;
      op_q        <= OP_LOAD;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      clr_cnt_q   <= clr_cnt_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  // Reset must never let an in-flight write or accept reach the BRAM/sequencer.
  assign mem_we    = we_c & rsta_n;
  assign cmd_ready = ready_c & rsta_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Self-checking bench for d_mem_ctrl with a NOREG BRAM model and a tape-level reference model.
module tb_d_mem_ctrl;
  import d_mem_ctrl_pkg::*;

  logic       clka;
  logic       rsta_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic [5:0] ptr;
  logic [5:0] mem_addr;
  logic [7:0] mem_di;
  logic       mem_we;
  logic [7:0] mem_do;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [64];
  logic [5:0] ref_ptr;
  logic [7:0] ref_rsp;

  logic [7:0] bram [64];

  d_mem_ctrl #(
    .ADDR_W(6),
    .DATA_W(8),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clka     (clka),
    .rsta_n   (rsta_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_zero (rsp_zero),
    .ptr      (ptr),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_we   (mem_we),
    .mem_do   (mem_do)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // NOREG, NORMAL-mode single-port BRAM: output holds during a write.
  always @(posedge clka) begin
    if (mem_we) bram[mem_addr] <= mem_di;
    else        mem_do <= bram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_and_clear();
    @(posedge clka); #1;
    rsta_n = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clka);
    check("we_in_reset", 32'(mem_we), 32'd0);
    @(posedge clka); #1;
    check("reset_vals", 32'({cmd_ready, rsp_valid, rsp_data, rsp_zero, ptr, mem_we}),
          32'({1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0}));
    @(posedge clka); #1;
    rsta_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clka);
      check($sformatf("clear_%0d", i), 32'({mem_we, mem_addr, mem_di, cmd_ready}),
            32'({1'b1, 6'(i), 8'h00, 1'b0}));
    end
    @(negedge clka);
    check("clear_done", 32'({cmd_ready, ptr, mem_we}), 32'({1'b1, 6'd0, 1'b0}));
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    ref_ptr = 6'd0;
    ref_rsp = 8'h00;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] data);
    int n;
    int exp_lat;
    @(posedge clka); #1;
    check("rsp_single_cycle", 32'(rsp_valid), 32'd0);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    n = 0;
    @(negedge clka);
    while (!cmd_ready && n < 8) begin
      @(negedge clka);
      n++;
    end
    check("accept", 32'(cmd_ready), 32'd1);
    if (op == OP_STORE)
      check("store_write", 32'({mem_we, mem_addr, mem_di}), 32'({1'b1, ref_ptr, data}));
    else
      check("idle_no_write", 32'(mem_we), 32'd0);

    exp_lat = 1;
    case (op)
      OP_INC: begin
        ref_mem[ref_ptr] = ref_mem[ref_ptr] + 8'd1;
        ref_rsp = ref_mem[ref_ptr];
        exp_lat = 2;
      end
      OP_DEC: begin
        ref_mem[ref_ptr] = ref_mem[ref_ptr] - 8'd1;
        ref_rsp = ref_mem[ref_ptr];
        exp_lat = 2;
      end
      OP_LOAD: begin
        ref_rsp = ref_mem[ref_ptr];
        exp_lat = 2;
      end
      OP_RIGHT: ref_ptr = ref_ptr + 6'd1;
      OP_LEFT:  ref_ptr = ref_ptr - 6'd1;
      OP_STORE: begin
        ref_mem[ref_ptr] = data;
        ref_rsp = data;
      end
      default: ;
    endcase

    @(posedge clka); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom);
    cmd_data = 8'($urandom);
    n = 1;
    @(negedge clka);
    while (!rsp_valid && n < 6) begin
      @(negedge clka);
      n++;
    end
    check("rsp_latency", 32'(n), 32'(exp_lat));
    check("rsp_data", 32'(rsp_data), 32'(ref_rsp));
    check("rsp_zero", 32'(rsp_zero), 32'(ref_rsp == 8'h00));
    check("ptr", 32'(ptr), 32'(ref_ptr));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bram[i] = 8'($urandom);
    rsta_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = 8'd0;
    ref_ptr = 6'd0;
    ref_rsp = 8'h00;

    reset_and_clear();

    do_cmd(OP_INC, 8'h00);
    do_cmd(OP_INC, 8'h00);
    do_cmd(OP_INC, 8'h00);
    do_cmd(OP_LOAD, 8'h00);

    do_cmd(OP_RIGHT, 8'h00);
    do_cmd(OP_DEC, 8'h00);
    do_cmd(OP_INC, 8'h00);
    do_cmd(3'd6, 8'h77);

    do_cmd(OP_LEFT, 8'h00);
    do_cmd(OP_LEFT, 8'h00);
    do_cmd(OP_STORE, 8'hA5);
    do_cmd(OP_RIGHT, 8'h00);
    do_cmd(OP_LOAD, 8'h00);
    do_cmd(OP_LEFT, 8'h00);
    do_cmd(OP_LOAD, 8'h00);

    // Reset during the WAIT cycle of an INC at ptr 63.
    @(posedge clka); #1;
    cmd_valid = 1'b1;
    cmd_op = OP_INC;
    @(negedge clka);
    check("abort_accept", 32'(cmd_ready), 32'd1);
    @(posedge clka); #1;
    cmd_valid = 1'b0;
    rsta_n = 1'b0;
    @(negedge clka);
    check("abort_no_we", 32'(mem_we), 32'd0);
    @(posedge clka); #1;
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    check("abort_cell_kept", 32'(bram[63]), 32'h0A5);
    reset_and_clear();
    do_cmd(OP_LOAD, 8'h00);

    // Back-to-back INC then LOAD with cmd_valid held.
    @(posedge clka); #1;
    cmd_valid = 1'b1;
    cmd_op = OP_INC;
    @(negedge clka);
    check("b2b_ready0", 32'(cmd_ready), 32'd1);
    @(posedge clka); #1;
    cmd_op = OP_LOAD;
    @(negedge clka);
    check("b2b_wait_busy", 32'({cmd_ready, rsp_valid}), 32'd0);
    @(negedge clka);
    check("b2b_rsp1", 32'({rsp_valid, rsp_data, cmd_ready}), 32'({1'b1, 8'h01, 1'b1}));
    @(posedge clka); #1;
    cmd_valid = 1'b0;
    @(negedge clka);
    check("b2b_wait2_busy", 32'({cmd_ready, rsp_valid}), 32'd0);
    @(negedge clka);
    check("b2b_rsp2", 32'({rsp_valid, rsp_data, rsp_zero}), 32'({1'b1, 8'h01, 1'b0}));
    ref_mem[0] = 8'h01;
    ref_rsp = 8'h01;

    // RIGHT twice on consecutive cycles.
    @(posedge clka); #1;
    cmd_valid = 1'b1;
    cmd_op = OP_RIGHT;
    @(negedge clka);
    check("right_ready", 32'(cmd_ready), 32'd1);
    @(posedge clka); #1;
    @(negedge clka);
    check("right1", 32'({ptr, cmd_ready, rsp_valid}), 32'({6'd1, 1'b1, 1'b1}));
    @(posedge clka); #1;
    cmd_valid = 1'b0;
    @(negedge clka);
    check("right2", 32'({ptr, rsp_valid}), 32'({6'd2, 1'b1}));
    ref_ptr = 6'd2;

    for (int k = 0; k < 200; k++)
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
